// File: rtl/subservient_pkg.sv
// Shared constants for the subservient machine timer.
// Register offsets (adr[3:2]) and CTRL field positions.
package subservient_pkg;

  localparam logic [1:0] TMR_MTIME = 2'd0;
  localparam logic [1:0] TMR_CMP   = 2'd1;
  localparam logic [1:0] TMR_CTRL  = 2'd2;
  localparam logic [1:0] TMR_STAT  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQEN   = 1;
  localparam int CTRL_DIV_LSB = 8;

endpackage

// File: rtl/subservient_timer_wb_regs.sv
// Wishbone slave front end for the timer.
// Decode, byte-lane masks, ack and registered read data.
module subservient_timer_wb_regs
  import subservient_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_adr,
  input  logic [31:0] i_dat,
  input  logic [3:0]  i_sel,
  input  logic        i_we,
  input  logic        i_stb,
  input  logic [31:0] i_mtime,
  input  logic [31:0] i_cmp,
  input  logic [31:0] i_ctrl,
  input  logic [31:0] i_stat,
  output logic        o_we_mtime,
  output logic        o_we_cmp,
  output logic        o_we_ctrl,
  output logic [31:0] o_wmask,
  output logic [31:0] o_wdat,
  output logic [31:0] o_rdt,
  output logic        o_ack
);

  logic        ack_q;
  logic        ack_d;
  logic [31:0] rdt_q;
  logic [31:0] rdt_d;
  logic [31:0] rd_mux;
  logic        access;

  assign access = i_stb & ~ack_q;

  // Expand byte enables into a bit mask and gate write data
  always_comb begin
    o_wmask = {{8{i_sel[3]}}, {8{i_sel[2]}},
               {8{i_sel[1]}}, {8{i_sel[0]}}};
    o_wdat  = i_dat & o_wmask;
  end

  // Address decode: write pulses and read mux
  always_comb begin
    o_we_mtime = 1'b0;
    o_we_cmp   = 1'b0;
    o_we_ctrl  = 1'b0;
    rd_mux     = '0;
    unique case (i_adr)
      TMR_MTIME: begin
        rd_mux     = i_mtime;
        o_we_mtime = access & i_we;
      end
      TMR_CMP: begin
        rd_mux   = i_cmp;
        o_we_cmp = access & i_we;
      end
      TMR_CTRL: begin
        rd_mux    = i_ctrl;
        o_we_ctrl = access & i_we;
      end
      TMR_STAT: begin
        rd_mux = i_stat;
      end
    endcase
  end

  // Ack one cycle after stb; read data only moves on a read access
  always_comb begin
    ack_d = access;
    rdt_d = (access & ~i_we) ? rd_mux : rdt_q;
  end

  // Bus response registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q <= 1'b0;
      rdt_q <= '0;
    end else begin
      ack_q <= ack_d;
      rdt_q <= rdt_d;
    end
  end

  assign o_ack = ack_q;
  assign o_rdt = rdt_q;

endmodule

// File: rtl/subservient_timer.sv
// Machine timer: prescaled mtime, mtimecmp and level irq.
// Bus decode lives in subservient_timer_wb_regs.
module subservient_timer
  import subservient_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  logic [WIDTH-1:0]   mtime_q, mtime_d;
  logic [WIDTH-1:0]   cmp_q, cmp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] div_q, div_d;
  logic               en_q, en_d;
  logic               irqen_q, irqen_d;
  logic               irq_q, irq_d;

  logic        we_mtime, we_cmp, we_ctrl;
  logic [31:0] wmask, wdat;
  logic [31:0] mtime_rd, cmp_rd, ctrl_rd, stat_rd;
  logic [31:0] mtime_wr, cmp_wr, ctrl_wr;
  logic        match;
  logic        unused_ok;

  assign match = mtime_q >= cmp_q;

  // 32-bit views of the registers and byte-merged write values
  always_comb begin
    mtime_rd = '0;
    mtime_rd[WIDTH-1:0] = mtime_q;
    cmp_rd = '0;
    cmp_rd[WIDTH-1:0] = cmp_q;
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN] = en_q;
    ctrl_rd[CTRL_IRQEN] = irqen_q;
    ctrl_rd[CTRL_DIV_LSB +: PRESC_W] = div_q;
    stat_rd = {31'b0, match};
    mtime_wr = (mtime_rd & ~wmask) | wdat;
    cmp_wr   = (cmp_rd & ~wmask) | wdat;
    ctrl_wr  = (ctrl_rd & ~wmask) | wdat;
  end

  assign unused_ok = ^{i_wb_adr[31:4], i_wb_adr[1:0],
                       mtime_wr, cmp_wr, ctrl_wr};

  subservient_timer_wb_regs u_regs (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_adr      (i_wb_adr[3:2]),
    .i_dat      (i_wb_dat),
    .i_sel      (i_wb_sel),
    .i_we       (i_wb_we),
    .i_stb      (i_wb_stb),
    .i_mtime    (mtime_rd),
    .i_cmp      (cmp_rd),
    .i_ctrl     (ctrl_rd),
    .i_stat     (stat_rd),
    .o_we_mtime (we_mtime),
    .o_we_cmp   (we_cmp),
    .o_we_ctrl  (we_ctrl),
    .o_wmask    (wmask),
    .o_wdat     (wdat),
    .o_rdt      (o_wb_rdt),
    .o_ack      (o_wb_ack)
  );

  // Prescaler, counter, bus writes (bus write to mtime wins)
  always_comb begin
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    presc_d = presc_q;
    div_d   = div_q;
    en_d    = en_q;
    irqen_d = irqen_q;
    if (en_q) begin
      if (presc_q == div_q) begin
        presc_d = '0;
        mtime_d = mtime_q + WIDTH'(1);
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
    if (we_ctrl) begin
      en_d    = ctrl_wr[CTRL_EN];
      irqen_d = ctrl_wr[CTRL_IRQEN];
      div_d   = ctrl_wr[CTRL_DIV_LSB +: PRESC_W];
      presc_d = '0;
    end
    if (we_mtime) mtime_d = mtime_wr[WIDTH-1:0];
    if (we_cmp)   cmp_d   = cmp_wr[WIDTH-1:0];
    irq_d = irqen_q & match;
  end

  // Timer state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      presc_q <= '0;
      div_q   <= '0;
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      en_q    <= en_d;
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
    end
  end

  assign o_timer_irq = irq_q;

endmodule
